param_reg_file: RTL and testbench
=================================

Name: param_reg_file

Overview:
Parametrised register file: DEPTH words of WIDTH bits, one write port and two independent read ports.
- Per-port write enable; optional hardwired-zero register 0.
- Sequenced bulk-clear engine with busy indication.
- Intended as the general storage block for the datapath, replacing fixed 32-bit single-register storage.

Parameters:
WIDTH, 32, data width of each register in bits.
DEPTH, 32, number of registers (2..256, need not be a power of 2).
ADDR_W, $clog2(DEPTH), address width (derived; not overridden).
ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
wr_en  input  1  write request this cycle.
wr_addr  input  ADDR_W  write address.
wr_data  input  WIDTH  write data.
wr_ack  output  1  registered pulse: previous cycle's write was committed.
rd_addr_a  input  ADDR_W  read port A address.
rd_data_a  output  WIDTH  read port A data.
rd_addr_b  input  ADDR_W  read port B address.
rd_data_b  output  WIDTH  read port B data.
clr_req  input  1  request bulk clear of all registers.
busy  output  1  clear sequence in progress.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- On reset (at the clk edge with rst=1):
  - all registers become 0;
  - busy=0, wr_ack=0;
  - FSM enters IDLE and the clear pointer becomes 0.
- Reset overrides everything, including an in-progress clear.
- Reads:
  - Combinational, zero latency: rd_data_x = reg[rd_addr_x].
  - Address >= DEPTH reads 0.
  - With ZERO_REG=1, address 0 reads 0.
- Write acceptance: a write is accepted when all of the following hold:
  - wr_en=1 and busy=0;
  - wr_addr < DEPTH;
  - not (ZERO_REG=1 and wr_addr=0).
- Accepted write effect: reg[wr_addr] <= wr_data at the edge, and wr_ack=1 in the following cycle only.
- Rejected write: no state change and wr_ack=0. There is no queueing; the producer must retry.
- FSM states IDLE and CLEAR.
  - IDLE -> CLEAR on clr_req=1.
  - Entering CLEAR sets ptr=0 and busy=1.
  - In CLEAR, each cycle reg[ptr] <= 0 and ptr increments.
  - When ptr=DEPTH-1 the FSM returns to IDLE and busy=0 at the next edge.
- Clear timing: if clr_req is sampled at edge N, busy is high from N through the edge at N+DEPTH. Exactly DEPTH clearing cycles, with busy low again after edge N+DEPTH.
- clr_req while busy=1 is ignored; it is not latched.
- wr_en and clr_req together in IDLE: the write is committed and acknowledged, clear starts the same edge, and the written register is zeroed when ptr reaches it.
- Reads during CLEAR return current contents: registers below ptr read 0, the rest hold old values.
- No arithmetic beyond the ptr increment. ptr is ADDR_W bits wide and never wraps past DEPTH-1.

Optional Feature:
Macro: PARAM_REG_FILE_BYPASS_EN.
- Defined: if a write is accepted this cycle and rd_addr_x == wr_addr, rd_data_x = wr_data combinationally (write-through forwarding). The zero-register and out-of-range rules still take priority.
- Undefined: reads return the pre-edge stored value; new data is visible the cycle after the write.

Decomposition:
- Package reg_file_pkg holds:
  - state enum reg_file_state_t {IDLE, CLEAR};
  - default constants RF_WIDTH=32 and RF_DEPTH=32.
- Sub-module reg_file_clear_ctrl holds the FSM, ptr, busy and the per-cycle clear strobe/address.
- Storage, read muxing, write qualification and wr_ack stay in the top level.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 5 -> wr_ack=1 next cycle; rd_addr_a=5 and rd_addr_b=5 both return 0xDEADBEEF.
- ZERO_REG=1, write 0xFFFFFFFF to addr 0 -> wr_ack stays 0; rd_data_a at addr 0 = 0.
- Fill all 32 registers with value=index+1, pulse clr_req -> busy high for exactly 32 cycles; at mid-clear (ptr=16) reg 15 reads 0 and reg 16 reads 17; afterwards all read 0.
- Write to addr 3 while busy=1 -> wr_ack=0 and reg 3 unchanged after clear. wr_en with clr_req in the same IDLE cycle -> wr_ack=1, reg later zeroed.
- Assert rst at clear cycle 10 -> next cycle busy=0 and all registers 0; clr_req after that starts a fresh 32-cycle clear.
- With PARAM_REG_FILE_BYPASS_EN: write 0x12345678 to addr 7 with rd_addr_a=7 -> rd_data_a=0x12345678 in the same cycle. Without the macro it shows the old value until after the edge.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the parametrised register file.
package reg_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } reg_file_state_t;

    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;

endpackage

// File: rtl/reg_file_clear_ctrl.sv
// Bulk-clear sequencer: walks ptr from 0 to DEPTH-1, strobing one
// register per cycle while busy is high.
module reg_file_clear_ctrl
    import reg_file_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    reg_file_state_t   state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                // ptr parks on the last index rather than wrapping
                if (ptr_q == LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign clr_en   = (state_q == CLEAR);
    assign clr_addr = ptr_q;

endmodule

// File: rtl/param_reg_file.sv
// DEPTH x WIDTH register file, one write and two read ports, bulk clear.
// Define PARAM_REG_FILE_BYPASS_EN for write-through read forwarding.
module param_reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              wr_ack,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    input  logic              clr_req,
    output logic              busy
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic              wr_ack_q, wr_ack_d;
    logic              wr_ok;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;

    // Address names a real, writable/readable storage word
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_X) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    reg_file_clear_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    assign wr_ok    = wr_en && !busy && addr_ok(wr_addr);
    assign wr_ack_d = wr_ok;

    // Write and clear strobes are never active together (clear implies busy)
    always_comb begin
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[wr_addr] = wr_data;
        end
        if (clr_en) begin
            mem_d[clr_addr] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ack_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ack_q <= wr_ack_d;
        end
    end

    assign wr_ack = wr_ack_q;

    always_comb begin
        rd_data_a = '0;
        if (addr_ok(rd_addr_a)) begin
            rd_data_a = mem_q[rd_addr_a];
        end
`ifdef PARAM_REG_FILE_BYPASS_EN
        if (wr_ok && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end
`endif
    end

    always_comb begin
        rd_data_b = '0;
        if (addr_ok(rd_addr_b)) begin
            rd_data_b = mem_q[rd_addr_b];
        end
`ifdef PARAM_REG_FILE_BYPASS_EN
        if (wr_ok && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end
`endif
    end

endmodule

// File: tb/tb_param_reg_file.sv
// Self-checking bench for param_reg_file (32 x 32, zero register on).
module tb_param_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic [4:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic        clr_req;
    logic        busy;

    param_reg_file dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .clr_req   (clr_req),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference: plain array plus a "cleared so far" count while clearing
    logic [31:0] m_mem [32];
    bit          m_busy;
    int          m_done;
    bit          m_ack;

    logic [31:0] s_a, s_b;
    logic        s_busy, s_ack;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_busy = 0;
        m_done = 0;
        m_ack  = 0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit acc,
                                           input logic [4:0] wa,
                                           input logic [31:0] wd);
        if (ra == 0) return '0;
`ifdef PARAM_REG_FILE_BYPASS_EN
        if (acc && ra == wa) return wd;
`endif
        return m_mem[ra];
    endfunction

    task automatic step(input bit r, input bit we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] ra,
                        input logic [4:0] rb, input bit cr);
        bit acc;
        @(negedge clk);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr_a = ra; rd_addr_b = rb; clr_req = cr;
        #1;
        s_a = rd_data_a; s_b = rd_data_b; s_busy = busy; s_ack = wr_ack;
        acc = we && !m_busy && (wa != 0);
        chk("rd_a", s_a, exp_rd(ra, acc, wa, wd));
        chk("rd_b", s_b, exp_rd(rb, acc, wa, wd));
        chk("busy", {31'b0, s_busy}, {31'b0, m_busy});
        chk("wr_ack", {31'b0, s_ack}, {31'b0, m_ack});
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            m_ack = acc;
            if (m_busy) begin
                m_mem[m_done] = '0;
                m_done++;
                if (m_done == 32) m_busy = 0;
            end else if (cr) begin
                m_busy = 1;
                m_done = 0;
            end
            if (acc) m_mem[wa] = wd;
        end
    endtask

    task automatic nop(input logic [4:0] ra, input logic [4:0] rb);
        step(0, 0, '0, '0, ra, rb, 0);
    endtask

    typedef struct {
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
        bit          eack;
    } vec_t;

    vec_t tbl [8];
    int   bcnt;

    initial begin
        tbl[0] = '{1, 5,  32'hDEADBEEF, 1,  2,  32'h0,        32'h0,        0};
        tbl[1] = '{0, 0,  32'h0,        5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 1};
        tbl[2] = '{1, 0,  32'hFFFFFFFF, 5,  1,  32'hDEADBEEF, 32'h0,        0};
        tbl[3] = '{0, 0,  32'h0,        0,  0,  32'h0,        32'h0,        0};
        tbl[4] = '{1, 31, 32'hA5A5A5A5, 5,  1,  32'hDEADBEEF, 32'h0,        0};
        tbl[5] = '{0, 0,  32'h0,        31, 0,  32'hA5A5A5A5, 32'h0,        1};
        tbl[6] = '{1, 10, 32'h00000001, 31, 5,  32'hA5A5A5A5, 32'hDEADBEEF, 0};
        tbl[7] = '{0, 0,  32'h0,        10, 31, 32'h00000001, 32'hA5A5A5A5, 1};

        rst = 1; wr_en = 0; wr_addr = 0; wr_data = 0;
        rd_addr_a = 0; rd_addr_b = 0; clr_req = 0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state: everything reads zero, idle
        for (int i = 0; i < 32; i += 2) nop(5'(i), 5'(i + 1));

        for (int i = 0; i < 8; i++) begin
            step(0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb, 0);
            chk("tbl_a", s_a, tbl[i].ea);
            chk("tbl_b", s_b, tbl[i].eb);
            chk("tbl_ack", {31'b0, s_ack}, {31'b0, tbl[i].eack});
        end

        // Same-cycle read of the register being written
        step(0, 1, 7, 32'h12345678, 7, 6, 0);
`ifdef PARAM_REG_FILE_BYPASS_EN
        chk("bypass_same", s_a, 32'h12345678);
`else
        chk("nobypass_same", s_a, 32'h0);
`endif
        nop(7, 7);
        chk("after_write", s_a, 32'h12345678);

        // Fill, clear, mid-clear snapshot, write while busy
        for (int i = 0; i < 32; i++) step(0, 1, 5'(i), 32'(i + 1), 0, 0, 0);
        step(0, 0, 0, 0, 15, 16, 1);
        bcnt = 0;
        for (int k = 0; k < 40; k++) begin
            step(0, (k == 20), 3, 32'h00000BAD, 15, 16, 0);
            if (s_busy) bcnt++;
            if (k == 16) begin
                chk("mid_r15", s_a, 32'h0);
                chk("mid_r16", s_b, 32'd17);
            end
            if (k == 21) chk("busy_wr_ack", {31'b0, s_ack}, 32'h0);
        end
        chk("busy_cycles", 32'(bcnt), 32'd32);
        for (int i = 0; i < 32; i += 2) nop(5'(i), 5'(i + 1));
        nop(3, 3);
        chk("r3_after_clear", s_a, 32'h0);

        // Write together with clear request in IDLE
        step(0, 1, 9, 32'h00000055, 0, 0, 1);
        nop(9, 9);
        chk("wr_clr_ack", {31'b0, s_ack}, 32'h1);
        repeat (34) nop(9, 8);
        chk("wr_clr_zeroed", s_a, 32'h0);

        // Reset in the middle of a clear, then a fresh clear
        step(0, 1, 4, 32'h44, 0, 0, 0);
        step(0, 1, 20, 32'h2020, 0, 0, 0);
        step(0, 0, 0, 0, 4, 20, 1);
        repeat (10) nop(4, 20);
        step(1, 0, 0, 0, 4, 20, 0);
        nop(4, 20);
        chk("rst_busy", {31'b0, s_busy}, 32'h0);
        chk("rst_r4", s_a, 32'h0);
        chk("rst_r20", s_b, 32'h0);
        step(0, 0, 0, 0, 0, 0, 1);
        bcnt = 0;
        for (int k = 0; k < 36; k++) begin
            nop(5'(k), 5'(k + 1));
            if (s_busy) bcnt++;
        end
        chk("busy_cycles2", 32'(bcnt), 32'd32);

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 2) != 0),
                 5'($urandom), $urandom,
                 5'($urandom), 5'($urandom),
                 ($urandom_range(0, 39) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
